// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its users.
// Holds the loader state enum, opcodes and instruction field widths.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LOAD = 4'b0011;

  localparam int OPC_W   = 4;
  localparam int RD_W    = 2;
  localparam int RS_W    = 2;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = OPC_W + RD_W + RS_W + IMM_W;

  function automatic logic [INSTR_W-1:0] pack_word(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream valid/ready channel feeding the program loader.
// master drives in_data/in_valid; slave returns in_ready.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 16-bit words into instruction memory.
// Ports: clk, reset (async high), start, strm (byte channel), imem_* write
// bus, cpu_hold/done/error status and words_loaded count.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      strm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_n;
  logic [7:0]        r_idx;
  logic [7:0]        r_hi;
  logic [7:0]        r_csum;
  logic [7:0]        r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              w_ready;
  logic              w_xfer;
  logic [7:0]        w_byte;

  assign w_byte  = strm.in_data;
  assign w_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                   (r_state == S_LO)    || (r_state == S_CHECK);
  assign w_xfer  = strm.in_valid && w_ready;

  assign strm.in_ready = w_ready;
  assign imem_we       = (r_state == S_WRITE);
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign cpu_hold      = (r_state != S_DONE);
  assign done          = (r_state == S_DONE);
  assign error         = (r_state == S_ERR);
  assign words_loaded  = r_words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_xfer) w_next = (w_byte == 8'd0) ? S_CHECK : S_HI;
      end
      S_HI: begin
        if (w_xfer) w_next = S_LO;
      end
      S_LO: begin
        if (w_xfer) w_next = S_WRITE;
      end
      S_WRITE: begin
        // idx still holds the index of the word being written here
        w_next = (r_idx == r_n - 8'd1) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (w_xfer) w_next = (w_byte == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n     <= '0;
      r_idx   <= '0;
      r_hi    <= '0;
      r_csum  <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_words <= '0;
            r_csum  <= '0;
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            r_n    <= w_byte;
            r_csum <= w_byte;
            r_idx  <= '0;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            r_hi   <= w_byte;
            r_csum <= r_csum ^ w_byte;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            r_csum  <= r_csum ^ w_byte;
            r_wdata <= pack_word(r_hi, w_byte);
            // wraps naturally modulo 2^ADDR_W
            r_addr  <= LP_BASE + ADDR_W'(r_idx);
          end
        end
        S_WRITE: begin
          r_idx   <= r_idx + 8'd1;
          r_words <= r_words + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader (bases 0 and 254).
// Expected writes and results come from a frame-level reference model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef logic [7:0] bq_t[$];

  localparam int BASE1 = 254;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] d;
  logic       v;

  prog_loader_if if0();
  prog_loader_if if1();

  assign if0.in_data  = d;
  assign if0.in_valid = v;
  assign if1.in_data  = d;
  assign if1.in_valid = v;

  logic        we0, we1, hold0, hold1, done0, done1, err0, err1;
  logic [7:0]  addr0, addr1, words0, words1;
  logic [15:0] wd0, wd1;

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .strm(if0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .cpu_hold(hold0), .done(done0), .error(err0),
    .words_loaded(words0)
  );

  prog_loader #(.ADDR_W(8), .BASE_ADDR(BASE1)) u1 (
    .clk(clk), .reset(reset), .start(start), .strm(if1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .cpu_hold(hold1), .done(done1), .error(err1),
    .words_loaded(words1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [15:0] mem0[256];
  bit          in_frame = 1'b0;

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      q0.push_back({addr0, wd0});
      mem0[addr0] = wd0;
    end
    if (we1 === 1'b1) q1.push_back({addr1, wd1});
    if (in_frame) begin
      chk("ready_not_we", 32'(if0.in_ready), 32'(!we0));
      chk("hold_in_frame", 32'(hold0), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit lo, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        v = 1'b0;
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    d = b;
    v = 1'b1;
    guard = 0;
    while (!if0.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_wait", 32'(guard < 20), 32'd1);
    tick();
    v = 1'b0;
    d = 8'($urandom);
    if (lo) begin
      chk("we_after_lo0", 32'(we0), 32'd1);
      chk("we_after_lo1", 32'(we1), 32'd1);
      chk("ready_in_write", 32'(if0.in_ready), 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(if0.in_ready), 32'd0);
    chk({tag, "_we"}, 32'(we0), 32'd0);
    chk({tag, "_addr"}, 32'(addr0), 32'd0);
    chk({tag, "_wdata"}, 32'(wd0), 32'd0);
    chk({tag, "_hold"}, 32'(hold0), 32'd1);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_err"}, 32'(err0), 32'd0);
    chk({tag, "_words"}, 32'(words0), 32'd0);
    chk({tag, "_addr1"}, 32'(addr1), 32'd0);
    chk({tag, "_hold1"}, 32'(hold1), 32'd1);
  endtask

  task automatic frame(input bq_t fb, input bit gaps, input string tag);
    int         n;
    logic [7:0] x;
    bit         good;
    bit         lo;
    n = int'(fb[0]);
    x = 8'd0;
    for (int i = 0; i < fb.size() - 1; i++) x ^= fb[i];
    good = (x == fb[fb.size() - 1]);
    q0.delete();
    q1.delete();
    pulse_start();
    chk({tag, "_st_done"}, 32'(done0), 32'd0);
    chk({tag, "_st_err"}, 32'(err0), 32'd0);
    chk({tag, "_st_words"}, 32'(words0), 32'd0);
    chk({tag, "_st_hold"}, 32'(hold0), 32'd1);
    in_frame = 1'b1;
    for (int i = 0; i < fb.size(); i++) begin
      lo = (i >= 2) && (i <= 2 * n) && (i % 2 == 0);
      send(fb[i], lo, gaps);
    end
    in_frame = 1'b0;
    chk({tag, "_done"}, 32'(done0), 32'(good));
    chk({tag, "_err"}, 32'(err0), 32'(!good));
    chk({tag, "_hold"}, 32'(hold0), 32'(!good));
    chk({tag, "_words"}, 32'(words0), 32'(n));
    chk({tag, "_done1"}, 32'(done1), 32'(good));
    chk({tag, "_words1"}, 32'(words1), 32'(n));
    chk({tag, "_nwr0"}, 32'(q0.size()), 32'(n));
    chk({tag, "_nwr1"}, 32'(q1.size()), 32'(n));
    for (int j = 0; j < n && j < q0.size() && j < q1.size(); j++) begin
      chk({tag, "_wr0"}, 32'(q0[j]), {8'd0, 8'(j), fb[1 + 2 * j], fb[2 + 2 * j]});
      chk({tag, "_wr1"}, 32'(q1[j]),
          {8'd0, 8'(BASE1 + j), fb[1 + 2 * j], fb[2 + 2 * j]});
    end
  endtask

  function automatic bq_t rand_frame(input int n, input bit good);
    bq_t        f;
    logic [7:0] x;
    f.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 2 * n; i++) begin
      f.push_back(8'($urandom));
      x ^= f[f.size() - 1];
    end
    if (!good) x ^= 8'($urandom_range(1, 255));
    f.push_back(x);
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bq_t nom;
    bq_t bad;
    bq_t f;
    nom = '{8'h04, 8'h11, 8'h00, 8'h21, 8'h00, 8'h30, 8'h0A,
            8'h34, 8'h0F, 8'h35};
    bad = nom;
    bad[9] = 8'h36;
    reset = 1'b1;
    start = 1'b0;
    v = 1'b0;
    d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    frame(nom, 1'b0, "nominal");
    frame(nom, 1'b0, "reload");
    chk("reload_addr_wrap", 32'(q1.size() == 4 ? q1[2][23:16] : 8'hFF), 32'd0);
    frame(bad, 1'b0, "badsum");
    f = '{8'h00, 8'h00};
    frame(f, 1'b0, "empty");
    frame(nom, 1'b1, "gaps");
    for (int k = 0; k < 4; k++) begin
      f = rand_frame($urandom_range(1, 6), $urandom_range(0, 1) == 1);
      frame(f, 1'b1, "random");
    end
    f = rand_frame(255, 1'b1);
    frame(f, 1'b0, "full");

    q0.delete();
    q1.delete();
    pulse_start();
    in_frame = 1'b1;
    send(8'h04, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h21, 1'b0, 1'b0);
    in_frame = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    chk("midreset_word0", 32'(mem0[0]), 32'h1100);
    chk("midreset_nwr", 32'(q0.size()), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    frame(nom, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader and the write side of the pipeline processor's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instructions, high byte first. Each assembled word is written to instruction memory at consecutive addresses. The frame checksum is verified at the end, and the processor is held until a frame loads cleanly. This replaces hierarchical memory pokes in benches and gives the SoC a real boot path.

Parameters:
ADDR_W, 8, instruction-memory address width; must be >= 8.
BASE_ADDR, 0, address of the first loaded word.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse that begins a load.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction-memory write strobe.
imem_addr  output  ADDR_W  write address.
imem_wdata  output  16  write data, {hi_byte, lo_byte}.
cpu_hold  output  1  holds the processor in reset; high unless state is DONE.
done  output  1  the last frame loaded with a good checksum.
error  output  1  the last frame failed its checksum.
words_loaded  output  8  count of words written in the current or last frame.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, error=0, words_loaded=0.
  - Internal N, idx, hi, csum are all cleared.
- Frame format: count byte N (0..255), then 2N instruction bytes (hi then lo per word), then a checksum byte. The checksum is the XOR of the count byte and all 2N instruction bytes.
- Handshake:
  - A byte transfers on a rising edge when in_valid && in_ready.
  - in_ready is a function of state only: 1 in COUNT/HI/LO/CHECK, 0 otherwise.
  - in_data is ignored when no transfer occurs.
- States and transitions:
  - IDLE: wait for start, then go to COUNT; clear done, error, words_loaded and csum.
  - COUNT: on transfer, N<=byte and csum<=byte. Go to CHECK if byte==0, else go to HI with idx=0.
  - HI: on transfer, hi<=byte, csum^=byte, go to LO.
  - LO: on transfer, csum^=byte, register imem_wdata={hi,byte} and imem_addr=BASE_ADDR+idx, go to WRITE.
  - WRITE: lasts exactly one cycle with imem_we=1. idx++ and words_loaded++. Go to CHECK if idx==N-1, else go to HI.
  - CHECK: on transfer, go to DONE if byte==csum, else go to ERR.
  - DONE: done=1 and cpu_hold=0. On start, go to COUNT (clearing done and words_loaded, setting cpu_hold=1).
  - ERR: error=1 (sticky) and cpu_hold=1. On start, go to COUNT (clearing error).
- Timing:
  - Write latency: the LO byte accepted at edge t produces imem_we=1 for the cycle following t. No byte is accepted during the WRITE cycle.
  - done/error assert the cycle after the checksum byte is accepted.
  - Peak throughput is 2 bytes per 3 cycles.
- Boundaries:
  - start outside IDLE/DONE/ERR is ignored.
  - A stalled in_valid may hold any state indefinitely; there is no timeout.
  - N=0 writes nothing and goes straight to CHECK.
  - imem_addr wraps modulo 2^ADDR_W.
  - Reset mid-frame aborts immediately. Words already written stay in memory; no rollback.
  - imem_we is 0 in every state except WRITE.

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state enum;
  - opcode constants used by the processor and by benches: OP_ADD=4'b0001, OP_SUB=4'b0010, OP_LOAD=4'b0011;
  - instruction field widths: opcode 4, rd 2, rs 2, imm 8.
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Nominal load: start, then bytes 04,11,00,21,00,30,0A,34,0F,35. Required response:
  - imem writes are (0,0x1100), (1,0x2100), (2,0x300A), (3,0x340F);
  - done=1, cpu_hold=0, words_loaded=4, error=0.
- Bad checksum: same frame with final byte 36. All four writes still occur; error=1, done=0, cpu_hold=1.
- Empty frame: bytes 00,00. There are no imem_we pulses; done=1, words_loaded=0.
- Backpressure and gaps: nominal frame with in_valid toggled randomly. Required response:
  - identical writes and result;
  - in_ready=0 exactly in each WRITE cycle;
  - imem_we asserted on the cycle after each lo byte is accepted.
- Reset mid-frame: assert reset after byte 0x21 is accepted.
  - All outputs take their reset values asynchronously.
  - Word 0 remains in memory.
  - A following nominal frame loads correctly and asserts done.
- Reload and wrap: with BASE_ADDR=254 and ADDR_W=8, load the nominal frame, then start again from DONE.
  - Addresses are 254, 255, 0, 1.
  - done drops on start, and cpu_hold rises until the second checksum passes.
